// File: rtl/trading_pkg.sv
// Shared trading-path definitions: order side encodings, default field widths,
// and the order arbiter state enum.
package trading_pkg;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  localparam int DEF_QTY_W   = 16;
  localparam int DEF_PRICE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/order_token_bucket.sv
// Token-bucket order rate limiter: one token per REFILL_CYCLES, up to TOKENS_MAX.
// consume_i takes a token the same cycle; throttle_o is registered and tracks tokens==0.
module order_token_bucket #(
  parameter int TOKENS_MAX    = 8,
  parameter int REFILL_CYCLES = 100
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic consume_i,
  output logic available_o,
  output logic throttle_o
);

  localparam int TOK_W = $clog2(TOKENS_MAX + 1);
  localparam int CNT_W = $clog2(REFILL_CYCLES);
  localparam logic [TOK_W-1:0] TOK_FULL = TOK_W'(TOKENS_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFILL_CYCLES - 1);

  logic [CNT_W-1:0] refill_cnt_q, refill_cnt_d;
  logic [TOK_W-1:0] tokens_q, tokens_d;
  logic             throttle_q;
  logic             refill_tick;

  always_comb begin
    refill_tick  = (refill_cnt_q == CNT_LAST);
    refill_cnt_d = refill_tick ? '0 : refill_cnt_q + 1'b1;
    tokens_d     = tokens_q;
    // A refill and a consume in the same cycle cancel out.
    if (refill_tick && !consume_i && (tokens_q != TOK_FULL)) begin
      tokens_d = tokens_q + 1'b1;
    end else if (consume_i && !refill_tick && (tokens_q != '0)) begin
      tokens_d = tokens_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      refill_cnt_q <= '0;
      tokens_q     <= TOK_FULL;
      throttle_q   <= 1'b0;
    end else begin
      refill_cnt_q <= refill_cnt_d;
      tokens_q     <= tokens_d;
      throttle_q   <= (tokens_d == '0);
    end
  end

  assign available_o = (tokens_q != '0);
  assign throttle_o  = throttle_q;

endmodule

// File: rtl/order_tx_arbiter.sv
// Round-robin order arbiter with pre-trade position check and token-bucket throttle.
// Grant at T, ord_valid at T+2; ord_* held until ord_ready, no grants while busy.
module order_tx_arbiter
  import trading_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int QTY_W         = DEF_QTY_W,
  parameter int PRICE_W       = DEF_PRICE_W,
  parameter int TOKENS_MAX    = 8,
  parameter int REFILL_CYCLES = 100
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*QTY_W-1:0]     req_qty,
  input  logic [N_REQ*PRICE_W-1:0]   req_price,
  input  logic [N_REQ-1:0]           req_side,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           req_reject,
  input  logic [31:0]                current_position,
  input  logic [31:0]                config_max_position,
  output logic                       ord_valid,
  input  logic                       ord_ready,
  output logic [QTY_W-1:0]           ord_qty,
  output logic [PRICE_W-1:0]         ord_price,
  output logic                       ord_side,
  output logic [$clog2(N_REQ)-1:0]   ord_src,
  output logic                       throttle_active,
  output logic [31:0]                grant_count,
  output logic [31:0]                reject_count
);

  localparam int SRC_W = $clog2(N_REQ);

  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   rr_q, rr_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic               side_q, side_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [31:0]        grant_cnt_q, grant_cnt_d;
  logic [31:0]        reject_cnt_q, reject_cnt_d;

  logic               tok_avail;
  logic               tok_consume;
  logic               gnt_found;
  logic [SRC_W-1:0]   gnt_idx;
  logic [32:0]        pos_ext, qty_ext, projected, proj_abs;
  logic               risk_fail;

  order_token_bucket #(
    .TOKENS_MAX    (TOKENS_MAX),
    .REFILL_CYCLES (REFILL_CYCLES)
  ) u_token_bucket (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .consume_i   (tok_consume),
    .available_o (tok_avail),
    .throttle_o  (throttle_active)
  );

  // First valid requester at or above the pointer; index arithmetic wraps at N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[rr_q + SRC_W'(i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_q + SRC_W'(i);
      end
    end
  end

  // 33-bit two's-complement projection so the magnitude never overflows.
  always_comb begin
    pos_ext   = {current_position[31], current_position};
    qty_ext   = 33'(qty_q);
    projected = (side_q == SIDE_SELL) ? (pos_ext - qty_ext) : (pos_ext + qty_ext);
    proj_abs  = projected[32] ? (~projected + 33'd1) : projected;
    risk_fail = (qty_q == '0) || (proj_abs > {1'b0, config_max_position});
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    qty_d        = qty_q;
    price_d      = price_q;
    side_d       = side_q;
    src_d        = src_q;
    grant_cnt_d  = grant_cnt_q;
    reject_cnt_d = reject_cnt_q;
    req_ready    = '0;
    req_reject   = '0;
    tok_consume  = 1'b0;
    ord_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tok_avail && gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          qty_d              = req_qty[gnt_idx*QTY_W +: QTY_W];
          price_d            = req_price[gnt_idx*PRICE_W +: PRICE_W];
          side_d             = req_side[gnt_idx];
          src_d              = gnt_idx;
          rr_d               = gnt_idx + 1'b1;
          state_d            = CHECK;
        end
      end
      CHECK: begin
        if (risk_fail) begin
          req_reject[src_q] = 1'b1;
          reject_cnt_d      = reject_cnt_q + 32'd1;
          state_d           = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        ord_valid = 1'b1;
        if (ord_ready) begin
          grant_cnt_d = grant_cnt_q + 32'd1;
          tok_consume = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      qty_q        <= '0;
      price_q      <= '0;
      side_q       <= 1'b0;
      src_q        <= '0;
      grant_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      qty_q        <= qty_d;
      price_q      <= price_d;
      side_q       <= side_d;
      src_q        <= src_d;
      grant_cnt_q  <= grant_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign ord_qty      = qty_q;
  assign ord_price    = price_q;
  assign ord_side     = side_q;
  assign ord_src      = src_q;
  assign grant_count  = grant_cnt_q;
  assign reject_count = reject_cnt_q;

endmodule
